// File: rtl/imem_loader.sv
// Length-prefixed byte-stream loader that writes little-endian words into instruction memory.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_rst,
   output logic              busy,
   output logic              done,
   output logic              error
);

   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK,
`endif
      DONE,
      ERR
   } state_t;

   state_t            state_q;
   logic [15:0]       n_q;
   logic [ADDR_W-1:0] cnt_q;
   logic [1:0]        lane_q;
   logic [23:0]       wbuf_q;
   logic              byte_ready_q;
   logic              imem_we_q;
   logic [ADDR_W-1:0] imem_addr_q;
   logic [31:0]       imem_wdata_q;
   logic              cpu_rst_q;
   logic              busy_q;
   logic              done_q;
   logic              error_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]        csum_q;
`endif

   logic        xfer;
   logic        last_word;
   logic [15:0] n_d;
   logic [31:0] word_d;

   assign xfer      = byte_valid && byte_ready_q;
   assign last_word = (16'(cnt_q) == (n_q - 16'd1));
   assign n_d       = {byte_data, n_q[7:0]};
   assign word_d    = {byte_data, wbuf_q};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         n_q          <= '0;
         cnt_q        <= '0;
         lane_q       <= '0;
         wbuf_q       <= '0;
         byte_ready_q <= 1'b0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= '0;
         cpu_rst_q    <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q       <= '0;
`endif
      end else begin
         imem_we_q <= 1'b0;
         unique case (state_q)
            IDLE, DONE, ERR: begin
               if (start) begin
                  state_q      <= LEN_LO;
                  n_q          <= '0;
                  cnt_q        <= '0;
                  lane_q       <= '0;
                  byte_ready_q <= 1'b1;
                  cpu_rst_q    <= 1'b1;
                  busy_q       <= 1'b1;
                  done_q       <= 1'b0;
                  error_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum_q       <= '0;
`endif
               end else if (state_q == DONE) begin
                  // release the core one cycle after the final write strobe
                  done_q    <= 1'b1;
                  cpu_rst_q <= 1'b0;
               end
            end
            LEN_LO: begin
               if (xfer) begin
                  n_q[7:0] <= byte_data;
                  state_q  <= LEN_HI;
               end
            end
            LEN_HI: begin
               if (xfer) begin
                  n_q <= n_d;
                  if (n_d == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                     state_q      <= CHK;
`else
                     state_q      <= DONE;
                     byte_ready_q <= 1'b0;
                     busy_q       <= 1'b0;
`endif
                  end else if ({1'b0, n_d} > 17'(DEPTH)) begin
                     state_q      <= ERR;
                     byte_ready_q <= 1'b0;
                     busy_q       <= 1'b0;
                     error_q      <= 1'b1;
                  end else begin
                     state_q <= DATA;
                  end
               end
            end
            DATA: begin
               if (!byte_ready_q) begin
                  byte_ready_q <= 1'b1;
               end else if (xfer) begin
                  lane_q <= lane_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum_q <= csum_q ^ byte_data;
`endif
                  unique case (lane_q)
                     2'd0: wbuf_q[7:0]   <= byte_data;
                     2'd1: wbuf_q[15:8]  <= byte_data;
                     2'd2: wbuf_q[23:16] <= byte_data;
                     default: begin
                        imem_we_q    <= 1'b1;
                        imem_addr_q  <= cnt_q;
                        imem_wdata_q <= word_d;
                        cnt_q        <= cnt_q + 1'b1;
                        byte_ready_q <= 1'b0;
                        if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                           state_q <= CHK;
`else
                           state_q <= DONE;
                           busy_q  <= 1'b0;
`endif
                        end
                     end
                  endcase
               end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: begin
               if (!byte_ready_q) begin
                  byte_ready_q <= 1'b1;
               end else if (xfer) begin
                  byte_ready_q <= 1'b0;
                  busy_q       <= 1'b0;
                  if (byte_data == csum_q) begin
                     state_q <= DONE;
                  end else begin
                     state_q <= ERR;
                     error_q <= 1'b1;
                  end
               end
            end
`endif
            default: begin
               state_q      <= IDLE;
               byte_ready_q <= 1'b0;
               busy_q       <= 1'b0;
            end
         endcase
      end
   end

   assign byte_ready = byte_ready_q;
   assign imem_we    = imem_we_q;
   assign imem_addr  = imem_addr_q;
   assign imem_wdata = imem_wdata_q;
   assign cpu_rst    = cpu_rst_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued by stimulus
// and popped by an independent strobe monitor.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = 8'h00;
   logic        byte_ready;
   logic        imem_we;
   logic [7:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_rst;
   logic        busy;
   logic        done;
   logic        error;

   int checks = 0;
   int fails = 0;
   int strobes = 0;
   logic [7:0]  last_addr = 8'h00;
   logic [39:0] exp_q[$];
   logic [31:0] img[$];

   always #5 clk = ~clk;

   imem_loader #(.ADDR_W(8), .DEPTH(256)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_rst    (cpu_rst),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // monitor: every write strobe must match the head of the scoreboard
   always @(negedge clk) begin
      if (rst && imem_we) begin
         logic [39:0] e;
         strobes++;
         last_addr = imem_addr;
         if (exp_q.size() == 0) begin
            chk("unexpected_write", {24'h0, imem_addr}, 32'hFFFFFFFF);
         end else begin
            e = exp_q.pop_front();
            chk("wr_addr", {24'h0, imem_addr}, {24'h0, e[39:32]});
            chk("wr_data", imem_wdata, e[31:0]);
         end
      end
   end

   task automatic pulse_start();
      byte_valid = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send(input logic [7:0] b);
      int k = 0;
      byte_valid = 1'b1;
      byte_data  = b;
      while (!byte_ready && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (k >= 100) begin
         chk("send_timeout", 32'd0, 32'd1);
         byte_valid = 1'b0;
      end else begin
         @(negedge clk);
      end
   endtask

   task automatic load(input int gap, input int n, input bit bad);
      logic [7:0] cs;
      logic [7:0] b;
      logic [31:0] w;
      cs = 8'h00;
      pulse_start();
      send(n[7:0]);
      send(n[15:8]);
      for (int i = 0; i < n; i++) begin
         w = img[i];
         exp_q.push_back({i[7:0], w});
         for (int j = 0; j < 4; j++) begin
            b = w[8*j +: 8];
            cs = cs ^ b;
            send(b);
            if (gap != 0) begin
               byte_valid = 1'b0;
               @(negedge clk);
            end
         end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send(bad ? ~cs : cs);
`else
      if (bad) cs = ~cs;
`endif
      byte_valid = 1'b0;
   endtask

   task automatic wait_end(input bit ok);
      int k = 0;
      while (!(done || error) && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("end_done", {31'h0, done}, {31'h0, ok});
      chk("end_error", {31'h0, error}, {31'h0, !ok});
      chk("end_cpu_rst", {31'h0, cpu_rst}, {31'h0, !ok});
      chk("end_busy", {31'h0, busy}, 32'h0);
      chk("end_ready", {31'h0, byte_ready}, 32'h0);
      chk("sb_empty", exp_q.size(), 32'h0);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0;
      // reset state
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      chk("rst_cpu_rst", {31'h0, cpu_rst}, 32'h1);
      chk("rst_ready", {31'h0, byte_ready}, 32'h0);
      chk("rst_done", {31'h0, done}, 32'h0);
      chk("rst_error", {31'h0, error}, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_addr", {24'h0, imem_addr}, 32'h0);
      chk("rst_wdata", imem_wdata, 32'h0);
      chk("rst_no_we", strobes, 32'h0);

      // two-word load with exact release timing
      img = '{32'h00000013, 32'hDEADBEEF};
      load(0, 2, 1'b0);
`ifndef IMEM_LOADER_CHECKSUM_EN
      chk("last_we", {31'h0, imem_we}, 32'h1);
      chk("last_we_addr", {24'h0, imem_addr}, 32'h1);
      chk("last_cpu_rst_hold", {31'h0, cpu_rst}, 32'h1);
      chk("last_done_low", {31'h0, done}, 32'h0);
      @(negedge clk);
      chk("rel_done", {31'h0, done}, 32'h1);
      chk("rel_cpu_rst", {31'h0, cpu_rst}, 32'h0);
      chk("rel_we_single", {31'h0, imem_we}, 32'h0);
`endif
      wait_end(1'b1);

      // N=257 rejected
      s0 = strobes;
      pulse_start();
      chk("restart_cpu_rst", {31'h0, cpu_rst}, 32'h1);
      chk("restart_done_clr", {31'h0, done}, 32'h0);
      send(8'h01);
      send(8'h01);
      byte_valid = 1'b0;
      wait_end(1'b0);
      chk("n257_no_we", strobes - s0, 32'h0);

      // N=256 accepted, last address 0xFF
      img.delete();
      for (int i = 0; i < 256; i++) begin
         logic [7:0] v;
         v = i[7:0];
         img.push_back({v, ~v, v ^ 8'h5A, 8'hA5});
      end
      s0 = strobes;
      load(0, 256, 1'b0);
      wait_end(1'b1);
      chk("n256_count", strobes - s0, 32'd256);
      chk("n256_last_addr", {24'h0, last_addr}, 32'hFF);

      // zero length
      img.delete();
      s0 = strobes;
      load(0, 0, 1'b0);
      wait_end(1'b1);
      chk("n0_no_we", strobes - s0, 32'h0);

      // abort mid-load with reset, then reload
      pulse_start();
      send(8'h02);
      send(8'h00);
      exp_q.push_back({8'h00, 32'h11223344});
      send(8'h44);
      send(8'h33);
      send(8'h22);
      send(8'h11);
      send(8'h88);
      byte_valid = 1'b0;
      rst = 1'b0;
      #1;
      chk("abort_cpu_rst", {31'h0, cpu_rst}, 32'h1);
      chk("abort_ready", {31'h0, byte_ready}, 32'h0);
      chk("abort_busy", {31'h0, busy}, 32'h0);
      chk("abort_done", {31'h0, done}, 32'h0);
      chk("abort_error", {31'h0, error}, 32'h0);
      chk("abort_we", {31'h0, imem_we}, 32'h0);
      chk("abort_addr", {24'h0, imem_addr}, 32'h0);
      chk("abort_wdata", imem_wdata, 32'h0);
      chk("abort_sb", exp_q.size(), 32'h0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      img = '{32'hA5A50001, 32'h0BADF00D};
      load(0, 2, 1'b0);
      wait_end(1'b1);

      // backpressure: same image gap-free and with gaps
      img = '{32'h01020304, 32'hFFFFFFFF, 32'h80000001};
      s0 = strobes;
      load(0, 3, 1'b0);
      wait_end(1'b1);
      chk("bp_ref_count", strobes - s0, 32'd3);
      s0 = strobes;
      load(1, 3, 1'b0);
      wait_end(1'b1);
      chk("bp_gap_count", strobes - s0, 32'd3);

      // start while busy is ignored
      img = '{32'hCAFEF00D};
      exp_q.push_back({8'h00, 32'hCAFEF00D});
      pulse_start();
      send(8'h01);
      send(8'h00);
      send(8'h0D);
      send(8'hF0);
      pulse_start();
      chk("busy_start_busy", {31'h0, busy}, 32'h1);
      send(8'hFE);
      send(8'hCA);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send(8'h0D ^ 8'hF0 ^ 8'hFE ^ 8'hCA);
`endif
      byte_valid = 1'b0;
      wait_end(1'b1);

`ifdef IMEM_LOADER_CHECKSUM_EN
      // wrong checksum byte
      img = '{32'h12345678};
      load(0, 1, 1'b1);
      wait_end(1'b0);
`endif

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end

endmodule
